// File: rtl/chip8_fb_engine_if.sv
// CPU command handshake plus sprite-memory read port of the CHIP-8 framebuffer engine.
// master = CPU/memory side, slave = the engine.
interface chip8_fb_engine_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [3:0]  cmd_n;
    logic [11:0] cmd_addr;
    logic        cmd_wrap;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_n, cmd_addr, cmd_wrap,
        input  cmd_ready,
        input  mem_rd, mem_addr,
        output mem_rvalid, mem_rdata
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_n, cmd_addr, cmd_wrap,
        output cmd_ready,
        output mem_rd, mem_addr,
        input  mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/chip8_fb_engine.sv
// CHIP-8 framebuffer with sprite XOR-draw, clear and (with CHIP8_FB_SCROLL_EN defined) scroll.
// Without CHIP8_FB_SCROLL_EN the scroll opcodes complete as no-ops.
module chip8_fb_engine #(
    parameter int FB_W = 64,
    parameter int FB_H = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    chip8_fb_engine_if.slave      bus,
    output logic                  busy,
    output logic                  done,
    output logic                  collision,
    output logic [FB_W*FB_H-1:0]  display
);
    localparam int NPIX = FB_W * FB_H;
    localparam int IW   = $clog2(NPIX);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CLEAR = 3'd4;
    localparam logic [2:0] S_SHIFT = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [1:0] OP_DRAW  = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
`ifdef CHIP8_FB_SCROLL_EN
    localparam logic [1:0] OP_SCROLL_DOWN = 2'b10;
    localparam logic [1:0] OP_SCROLL_H    = 2'b11;
`endif

    logic [2:0]      state_q,  state_d;
    logic [7:0]      xOrg_q,   xOrg_d;
    logic [7:0]      yOrg_q,   yOrg_d;
    logic [3:0]      n_q,      n_d;
    logic [11:0]     addr_q,   addr_d;
    logic            wrap_q,   wrap_d;
    logic [6:0]      rowCnt_q, rowCnt_d;
    logic [7:0]      byte_q,   byte_d;
    logic            coll_q,   coll_d;
    logic [NPIX-1:0] fb_q,     fb_d;
`ifdef CHIP8_FB_SCROLL_EN
    logic [1:0]      op_q,     op_d;
    logic            left_q,   left_d;
`endif

    // rowCnt is shared: sprite row during a draw, row being zeroed during a clear.
    always_comb begin : nextState
        int            colPos;
        int            rowPos;
        logic          inView;
        logic [IW-1:0] pix;

        state_d  = state_q;
        xOrg_d   = xOrg_q;
        yOrg_d   = yOrg_q;
        n_d      = n_q;
        addr_d   = addr_q;
        wrap_d   = wrap_q;
        rowCnt_d = rowCnt_q;
        byte_d   = byte_q;
        coll_d   = coll_q;
        fb_d     = fb_q;
`ifdef CHIP8_FB_SCROLL_EN
        op_d     = op_q;
        left_d   = left_q;
`endif
        colPos   = 0;
        rowPos   = 0;
        inView   = 1'b0;
        pix      = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    xOrg_d   = bus.cmd_x & 8'(FB_W - 1);
                    yOrg_d   = bus.cmd_y & 8'(FB_H - 1);
                    n_d      = bus.cmd_n;
                    addr_d   = bus.cmd_addr;
                    wrap_d   = bus.cmd_wrap;
                    rowCnt_d = '0;
                    coll_d   = 1'b0;
`ifdef CHIP8_FB_SCROLL_EN
                    op_d     = bus.cmd_op;
                    left_d   = bus.cmd_x[0];
`endif
                    if (bus.cmd_op == OP_CLEAR)
                        state_d = S_CLEAR;
                    else if (bus.cmd_op == OP_DRAW && bus.cmd_n != 4'd0)
                        state_d = S_FETCH;
                    else
                        state_d = S_SHIFT;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    byte_d  = bus.mem_rdata;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // Clipped pixels are dropped; wrapped ones fold back modulo the screen size.
                for (int i = 0; i < 8; i++) begin
                    colPos = int'(xOrg_q) + i;
                    rowPos = int'(yOrg_q) + int'(rowCnt_q);
                    inView = wrap_q || (colPos < FB_W && rowPos < FB_H);
                    pix    = IW'((rowPos % FB_H) * FB_W + (colPos % FB_W));
                    if (byte_q[3'(7 - i)] && inView) begin
                        coll_d    = coll_d | fb_q[pix];
                        fb_d[pix] = ~fb_q[pix];
                    end
                end
                if (rowCnt_q + 7'd1 == {3'b000, n_q}) begin
                    state_d = S_DONE;
                end else begin
                    rowCnt_d = rowCnt_q + 7'd1;
                    state_d  = S_FETCH;
                end
            end
            S_CLEAR: begin
                fb_d[IW'(int'(rowCnt_q) * FB_W) +: FB_W] = '0;
                if (rowCnt_q == 7'(FB_H - 1))
                    state_d = S_DONE;
                else
                    rowCnt_d = rowCnt_q + 7'd1;
            end
            S_SHIFT: begin
                // Also the single settle cycle for DRAW with n=0 and disabled scroll ops.
`ifdef CHIP8_FB_SCROLL_EN
                if (op_q == OP_SCROLL_DOWN) begin
                    fb_d = fb_q << (int'(n_q) * FB_W);
                end else if (op_q == OP_SCROLL_H) begin
                    for (int r = 0; r < FB_H; r++) begin
                        fb_d[IW'(r * FB_W) +: FB_W] = left_q ? (fb_q[IW'(r * FB_W) +: FB_W] >> 4)
                                                             : (fb_q[IW'(r * FB_W) +: FB_W] << 4);
                    end
                end
`endif
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            xOrg_q   <= '0;
            yOrg_q   <= '0;
            n_q      <= '0;
            addr_q   <= '0;
            wrap_q   <= 1'b0;
            rowCnt_q <= '0;
            byte_q   <= '0;
            coll_q   <= 1'b0;
            fb_q     <= '0;
`ifdef CHIP8_FB_SCROLL_EN
            op_q     <= '0;
            left_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            xOrg_q   <= xOrg_d;
            yOrg_q   <= yOrg_d;
            n_q      <= n_d;
            addr_q   <= addr_d;
            wrap_q   <= wrap_d;
            rowCnt_q <= rowCnt_d;
            byte_q   <= byte_d;
            coll_q   <= coll_d;
            fb_q     <= fb_d;
`ifdef CHIP8_FB_SCROLL_EN
            op_q     <= op_d;
            left_q   <= left_d;
`endif
        end
    end

    // Strobes are masked by reset so nothing is requested or offered while it is held.
    assign bus.cmd_ready = (state_q == S_IDLE) && !reset;
    assign bus.mem_rd    = (state_q == S_FETCH) && !reset;
    assign bus.mem_addr  = addr_q + 12'(rowCnt_q);
    assign busy          = (state_q != S_IDLE) && !reset;
    assign done          = (state_q == S_DONE) && !reset;
    assign collision     = coll_q;
    assign display       = fb_q;
endmodule

// File: tb/tb_chip8_fb_engine.sv
// Self-checking bench for chip8_fb_engine: directed plan cases plus random draws against a pixel-array model.
// Scroll expectations follow CHIP8_FB_SCROLL_EN when it is defined.
module tb_chip8_fb_engine;
    localparam int FB_W = 64;
    localparam int FB_H = 32;
    localparam int NPIX = FB_W * FB_H;

    localparam logic [1:0] OP_DRAW  = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_SD    = 2'b10;
    localparam logic [1:0] OP_SH    = 2'b11;

    logic            clk;
    logic            reset;
    logic            busy;
    logic            done;
    logic            collision;
    logic [NPIX-1:0] display;

    chip8_fb_engine_if bus ();

    chip8_fb_engine #(.FB_W(FB_W), .FB_H(FB_H)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .collision (collision),
        .display   (display)
    );

    typedef struct {
        logic [11:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [11:0] rdLog[$];
    logic [7:0]  mem [4096];
    bit          refFb [FB_H][FB_W];
    bit          refColl;
    int          lat = 1;
    int          tick = 0;
    int          cyc = 0;
    int          assertCount = 0;
    int          failCount = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responds lat cycles after each strobe; rdata is garbage whenever rvalid is low.
    initial begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 8'h00;
        forever begin
            @(negedge clk);
            tick++;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 8'($urandom);
            if (pend.size() > 0 && pend[0].due <= tick) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = mem[pend[0].addr];
                void'(pend.pop_front());
            end
            if (bus.mem_rd) begin
                pend.push_back('{addr: bus.mem_addr, due: tick + lat});
                rdLog.push_back(bus.mem_addr);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [NPIX-1:0] modelImage();
        logic [NPIX-1:0] img;
        for (int y = 0; y < FB_H; y++)
            for (int x = 0; x < FB_W; x++)
                img[y * FB_W + x] = refFb[y][x];
        return img;
    endfunction

    task automatic checkDisplay(input string tag);
        logic [NPIX-1:0] expImg;
        int diffs;
        int first;
        expImg = modelImage();
        assertCount++;
        assert (display === expImg) else begin
            diffs = 0;
            first = 0;
            for (int k = NPIX - 1; k >= 0; k--)
                if (display[k] !== expImg[k]) begin
                    diffs++;
                    first = k;
                end
            failCount++;
            $error("FAIL %s: display differs in %0d pixels, first at bit %0d observed %b expected %b",
                   tag, diffs, first, display[first], expImg[first]);
        end
    endtask

    task automatic modelClear();
        for (int y = 0; y < FB_H; y++)
            for (int x = 0; x < FB_W; x++)
                refFb[y][x] = 1'b0;
    endtask

    task automatic modelDraw(input int x, input int y, input int n, input int addr, input bit wrap);
        logic [7:0] b;
        int cx;
        int cy;
        refColl = 1'b0;
        for (int r = 0; r < n; r++) begin
            b = mem[12'((addr + r) % 4096)];
            for (int i = 0; i < 8; i++) begin
                if (b[3'(7 - i)]) begin
                    cx = (x % FB_W) + i;
                    cy = (y % FB_H) + r;
                    if (wrap) begin
                        cx = cx % FB_W;
                        cy = cy % FB_H;
                    end
                    if (cx < FB_W && cy < FB_H) begin
                        if (refFb[cy][cx]) refColl = 1'b1;
                        refFb[cy][cx] = !refFb[cy][cx];
                    end
                end
            end
        end
    endtask

    task automatic modelScrollDown(input int n);
        bit tmp [FB_H][FB_W];
        for (int y = 0; y < FB_H; y++)
            for (int x = 0; x < FB_W; x++)
                if (y >= n) tmp[y][x] = refFb[y - n][x];
                else        tmp[y][x] = 1'b0;
        refFb = tmp;
    endtask

    task automatic modelScrollH(input bit left);
        bit tmp [FB_H][FB_W];
        for (int y = 0; y < FB_H; y++)
            for (int x = 0; x < FB_W; x++)
                if (left) tmp[y][x] = (x + 4 < FB_W) ? refFb[y][x + 4] : 1'b0;
                else      tmp[y][x] = (x >= 4) ? refFb[y][x - 4] : 1'b0;
        refFb = tmp;
    endtask

    task automatic nextCycle();
        @(negedge clk);
        cyc++;
    endtask

    // Presents one command and returns just after its acceptance edge (cycle 0).
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                                 input logic [3:0] n, input logic [11:0] addr, input logic wrap,
                                 input string tag);
        @(negedge clk);
        bus.cmd_op    = op;
        bus.cmd_x     = x;
        bus.cmd_y     = y;
        bus.cmd_n     = n;
        bus.cmd_addr  = addr;
        bus.cmd_wrap  = wrap;
        bus.cmd_valid = 1'b1;
        checkOutput({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
        rdLog.delete();
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        cyc = 0;
    endtask

    task automatic waitDone(input int expCycle, input string tag);
        int seenAt;
        seenAt = -1;
        while (cyc < 300) begin
            nextCycle();
            if (done) begin
                seenAt = cyc;
                break;
            end
        end
        checkOutput({tag, "_done_cycle"}, 32'(seenAt), 32'(expCycle));
    endtask

    task automatic runDraw(input int x, input int y, input int n, input int addr, input bit wrap,
                           input int latency, input string tag);
        lat = latency;
        modelDraw(x, y, n, addr, wrap);
        applyStimulus(OP_DRAW, 8'(x), 8'(y), 4'(n), 12'(addr), wrap, tag);
        waitDone((n == 0) ? 2 : n * (latency + 2) + 1, tag);
        checkOutput({tag, "_collision"}, 32'(collision), 32'(refColl));
        checkOutput({tag, "_rd_count"}, 32'(rdLog.size()), 32'(n));
        for (int k = 0; k < rdLog.size() && k < n; k++)
            checkOutput({tag, "_rd_addr"}, 32'(rdLog[k]), 32'((addr + k) % 4096));
        checkDisplay({tag, "_display"});
    endtask

    task automatic runClear(input string tag);
        modelClear();
        applyStimulus(OP_CLEAR, 8'd0, 8'd0, 4'd0, 12'd0, 1'b0, tag);
        waitDone(FB_H + 1, tag);
        checkDisplay({tag, "_display"});
    endtask

    initial begin
        int readyHigh;
        int seenAt;
        int fetches;
        int strayHigh;

        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_x     = 8'd0;
        bus.cmd_y     = 8'd0;
        bus.cmd_n     = 4'd0;
        bus.cmd_addr  = 12'd0;
        bus.cmd_wrap  = 1'b0;
        for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
        modelClear();

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready_low", 32'(bus.cmd_ready), 32'd0);
        checkOutput("rst_memrd_low", 32'(bus.mem_rd), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready_high", 32'(bus.cmd_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_collision", 32'(collision), 32'd0);
        checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkDisplay("rst_display");

        // Plan: single-row draw at (2,3), then the same draw again to erase it.
        mem[12'h300] = 8'hF0;
        runDraw(2, 3, 1, 12'h300, 1'b1, 1, "draw1");
        checkOutput("draw1_bits", 32'(display[197:194]), 32'hF);
        runDraw(2, 3, 1, 12'h300, 1'b1, 1, "draw2");
        checkOutput("draw2_coll_set", 32'(collision), 32'd1);

        modelClear();
        applyStimulus(OP_CLEAR, 8'd0, 8'd0, 4'd0, 12'd0, 1'b0, "clr1");
        nextCycle();
        checkOutput("accept_clears_coll", 32'(collision), 32'd0);
        checkOutput("clr1_busy", 32'(busy), 32'd1);
        waitDone(FB_H + 1, "clr1");
        checkDisplay("clr1_display");

        // Plan: corner sprite, wrap then clip.
        mem[12'h400] = 8'hFF;
        mem[12'h401] = 8'hFF;
        runDraw(62, 31, 2, 12'h400, 1'b1, 1, "wrap");
        checkOutput("wrap_px_63_31", 32'(display[31 * FB_W + 63]), 32'd1);
        checkOutput("wrap_px_5_0", 32'(display[5]), 32'd1);
        checkOutput("wrap_px_6_0", 32'(display[6]), 32'd0);
        runClear("clr2");
        runDraw(62, 31, 2, 12'h400, 1'b0, 1, "clip");
        checkOutput("clip_popcount", 32'($countones(display)), 32'd2);
        checkOutput("clip_px_62_31", 32'(display[31 * FB_W + 62]), 32'd1);

        // Plan: 3-cycle memory, n=4 across the 4 KiB address wrap, with cmd_valid held while busy.
        lat = 3;
        modelDraw(20, 7, 4, 12'hFFE, 1'b1);
        applyStimulus(OP_DRAW, 8'd20, 8'd7, 4'd4, 12'hFFE, 1'b1, "lat3");
        bus.cmd_op    = OP_CLEAR;
        bus.cmd_valid = 1'b1;
        readyHigh = 0;
        seenAt    = -1;
        while (cyc < 300) begin
            nextCycle();
            if (bus.cmd_ready) readyHigh++;
            if (done) begin
                seenAt = cyc;
                break;
            end
        end
        bus.cmd_valid = 1'b0;
        checkOutput("lat3_done_cycle", 32'(seenAt), 32'd21);
        checkOutput("lat3_ready_while_busy", 32'(readyHigh), 32'd0);
        checkOutput("lat3_rd_count", 32'(rdLog.size()), 32'd4);
        for (int k = 0; k < rdLog.size() && k < 4; k++)
            checkOutput("lat3_rd_addr", 32'(rdLog[k]), 32'((12'hFFE + k) % 4096));
        checkOutput("lat3_collision", 32'(collision), 32'(refColl));
        nextCycle();
        checkOutput("lat3_idle_after", 32'(busy), 32'd0);
        checkDisplay("lat3_display");

        // Random draws: origin, size, address, edge mode and memory latency all vary.
        for (int t = 0; t < 16; t++) begin
            runDraw(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    (t == 0) ? 0 : int'($urandom_range(1, 15)), int'($urandom_range(0, 4095)),
                    bit'($urandom_range(0, 1)), int'($urandom_range(1, 3)), "rnd");
        end

        mem[12'h500] = 8'hFF;
        runDraw(20, 10, 1, 12'h500, 1'b1, 1, "pre_sh");
        runDraw(20, 10, 1, 12'h500, 1'b1, 1, "pre_sh2");
        checkOutput("pre_sh2_coll", 32'(collision), 32'd1);
`ifdef CHIP8_FB_SCROLL_EN
        modelScrollH(1'b0);
`endif
        applyStimulus(OP_SH, 8'd0, 8'd0, 4'd0, 12'd0, 1'b0, "shr");
        waitDone(2, "shr");
        checkOutput("shr_collision", 32'(collision), 32'd0);
        checkDisplay("shr_display");

        // Plan: reset during WAIT of the third row fetch.
        lat = 3;
        mem[12'h600] = 8'hFF;
        mem[12'h601] = 8'hFF;
        applyStimulus(OP_DRAW, 8'd5, 8'd5, 4'd4, 12'h600, 1'b1, "rst_mid");
        fetches = 0;
        while (cyc < 100 && fetches < 3) begin
            nextCycle();
            if (bus.mem_rd) fetches++;
        end
        checkOutput("rst_mid_fetches", 32'(fetches), 32'd3);
        nextCycle();
        checkOutput("rst_mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_ready_low", 32'(bus.cmd_ready), 32'd0);
        checkOutput("rst_mid_memrd_low", 32'(bus.mem_rd), 32'd0);
        rdLog.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        modelClear();
        @(negedge clk);
        checkOutput("rst_mid_ready_high", 32'(bus.cmd_ready), 32'd1);
        checkDisplay("rst_mid_display");
        strayHigh = 0;
        for (int k = 0; k < 8; k++) begin
            nextCycle();
            if (busy || done || bus.mem_rd) strayHigh++;
        end
        checkOutput("rst_mid_quiet", 32'(strayHigh), 32'd0);
        checkOutput("rst_mid_no_rd", 32'(rdLog.size()), 32'd0);
        checkDisplay("rst_mid_display_late");

        // Plan: single lit pixel (10,5), scroll down 3 then left.
        mem[12'h700] = 8'h80;
        runDraw(10, 5, 1, 12'h700, 1'b1, 1, "dot");
`ifdef CHIP8_FB_SCROLL_EN
        modelScrollDown(3);
`endif
        applyStimulus(OP_SD, 8'd0, 8'd0, 4'd3, 12'd0, 1'b0, "sd3");
        waitDone(2, "sd3");
        checkDisplay("sd3_display");
`ifdef CHIP8_FB_SCROLL_EN
        checkOutput("sd3_px_10_8", 32'(display[8 * FB_W + 10]), 32'd1);
`else
        checkOutput("sd3_px_10_5", 32'(display[5 * FB_W + 10]), 32'd1);
`endif
`ifdef CHIP8_FB_SCROLL_EN
        modelScrollH(1'b1);
`endif
        applyStimulus(OP_SH, 8'd1, 8'd0, 4'd0, 12'd0, 1'b0, "shl");
        waitDone(2, "shl");
        checkDisplay("shl_display");
        checkOutput("shl_popcount", 32'($countones(display)), 32'd1);
        applyStimulus(OP_SD, 8'd0, 8'd0, 4'd0, 12'd0, 1'b0, "sd0");
        waitDone(2, "sd0");
        checkDisplay("sd0_display");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
